balls_overlay_axi_regs: RTL and testbench
=========================================

BALLS_OVERLAY_AXI_REGS -- requirements
Module: balls_overlay_axi_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4: byte-address width covering 4 registers.
REQ-003 ACLK  in  1  single clock; all logic is on the rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 S_AXI_AWADDR  in  4  write address.
REQ-006 S_AXI_AWPROT  in  3  ignored.
REQ-007 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
REQ-008 S_AXI_WDATA  in  32  write data.
REQ-009 S_AXI_WSTRB  in  4  byte enables.
REQ-010 S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
REQ-011 S_AXI_BRESP  out  2  write response, always 2'b00.
REQ-012 S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
REQ-013 S_AXI_ARADDR  in  4  read address.
REQ-014 S_AXI_ARPROT  in  3  ignored.
REQ-015 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
REQ-016 S_AXI_RDATA  out  32  read data.
REQ-017 S_AXI_RRESP  out  2  read response, always 2'b00.
REQ-018 S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
REQ-019 frame_start  in  1  one-cycle pulse at the video frame boundary.
REQ-020 regs_shadow  out  128  {reg3, reg2, reg1, reg0}, as latched at the last frame_start.
REQ-021 shadow_updated  out  1  one-cycle pulse, asserted the cycle after a frame_start is captured.

Function
REQ-022 Register select is ADDR[3:2] (0x0 reg0, 0x4 reg1, 0x8 reg2, 0xC reg3); ADDR[1:0] is ignored; every register is fully read/write.
REQ-023 The write FSM SHALL have exactly these states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-024 W_IDLE: AWREADY=1 and WREADY=1; AW+W in the same cycle -> W_RESP; AW only -> W_HAVE_AW; W only -> W_HAVE_W.
REQ-025 W_HAVE_AW: AWREADY=0, WREADY=1; W handshake -> W_RESP. W_HAVE_W: AWREADY=1, WREADY=0; AW handshake -> W_RESP.
REQ-026 The register write SHALL commit on the clock edge that enters W_RESP, updating only the bytes whose WSTRB bit is 1.
REQ-027 W_RESP: BVALID=1, AWREADY=0, WREADY=0; BVALID holds until BREADY=1, then -> W_IDLE; at most one write is outstanding.
REQ-028 The read FSM SHALL have exactly these states: R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
REQ-029 An AR handshake in R_IDLE SHALL register RDATA from the selected register on that edge and enter R_DATA, so RVALID rises 1 cycle after the handshake.
REQ-030 RDATA and RVALID SHALL hold stable in R_DATA until RREADY=1, then -> R_IDLE; back-to-back reads therefore take 2 cycles each minimum.
REQ-031 The read and write paths are independent. A read sampled on the same edge as a write commit to the same register returns the pre-write value.
REQ-032 frame_start=1 SHALL copy all four registers into regs_shadow on that edge. The copied values are pre-write values if a write commits on the same edge; that write appears at the next frame_start.
REQ-033 A frame_start arriving while shadow_updated is high SHALL be captured normally, and shadow_updated stays high one more cycle.

Reset
REQ-034 ARESETN=0 SHALL immediately force both FSMs to idle and set reg0..reg3=0, regs_shadow=0, BVALID=0, RVALID=0, RDATA=0, shadow_updated=0, AWREADY=0, WREADY=0, ARREADY=0.
REQ-035 From the first edge after ARESETN deasserts, the ready signals follow the idle-state values; a transaction in flight during reset is discarded with no response.

Verification
REQ-036 Write 1,2,3,4 to 0x0,0x4,0x8,0xC (WSTRB=0xF), then read the same addresses -> RDATA 1,2,3,4, RRESP=0, BRESP=0 each time.
REQ-037 AWVALID 3 cycles before WVALID to 0x8 with 0x12345678 -> state W_HAVE_AW with AWREADY=0; BVALID 1 cycle after the W handshake; read of 0x8 = 0x12345678.
REQ-038 reg1=0x00000002, then write 0xAABBCCDD with WSTRB=4'b0010 -> reg1 reads 0x0000CC02.
REQ-039 BREADY held low 5 cycles after a write -> BVALID stays 1 and AWREADY=WREADY=0 throughout; a second AWVALID is not accepted until the cycle after BREADY=1.
REQ-040 Write reg0=0xDEADBEEF, then pulse frame_start -> regs_shadow[31:0]=0xDEADBEEF and shadow_updated=1 for 1 cycle. A frame_start on the same edge as a write of 0x5 to reg0 -> shadow keeps the old value.
REQ-041 ARESETN=0 while in W_HAVE_AW and R_DATA -> BVALID=RVALID=0 immediately; after release, all registers read 0 and no stale B or R beat appears.

Source files
------------

// File: rtl/balls_overlay_axi_regs.sv
// AXI4-Lite slave holding four 32-bit overlay registers.
// The registers are copied into a frame-synchronous shadow on every frame_start pulse.
module balls_overlay_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              frame_start,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   regs_shadow,
  output logic                              shadow_updated,
  output logic [1:0]                        w_state_dbg,
  output logic                              r_state_dbg
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;

  // Debug encoding: 0 W_IDLE, 1 W_HAVE_AW, 2 W_HAVE_W, 3 W_RESP.
  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_HAVE_AW = 2'd1;
  localparam logic [1:0] W_HAVE_W  = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;
  localparam logic [0:0] R_IDLE    = 1'b0;
  localparam logic [0:0] R_DATA    = 1'b1;

  logic [1:0]        w_state, w_next;
  logic [0:0]        r_state;
  logic              ready_en;
  logic [1:0]        aw_sel_q;
  logic [DW-1:0]     w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic [DW-1:0]     regs [4];
  logic              aw_hs, w_hs, ar_hs;
  logic              do_commit;
  logic [1:0]        commit_sel;
  logic [DW-1:0]     commit_data;
  logic [STRB_W-1:0] commit_strb;
  logic              unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A beat transfers on a rising edge where VALID and READY are both high;
  // VALID, once raised by this slave, holds with its payload until READY.
  // ready_en keeps every READY low until the first edge after reset release.
  assign S_AXI_AWREADY = ready_en && (w_state == W_IDLE || w_state == W_HAVE_W);
  assign S_AXI_WREADY  = ready_en && (w_state == W_IDLE || w_state == W_HAVE_AW);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ready_en && (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RRESP   = 2'b00;
  assign w_state_dbg   = w_state;
  assign r_state_dbg   = r_state;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    w_next      = w_state;
    do_commit   = 1'b0;
    commit_sel  = S_AXI_AWADDR[3:2];
    commit_data = S_AXI_WDATA;
    commit_strb = S_AXI_WSTRB;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          do_commit = 1'b1;
          w_next    = W_RESP;
        end else if (aw_hs) begin
          w_next = W_HAVE_AW;
        end else if (w_hs) begin
          w_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          do_commit  = 1'b1;
          commit_sel = aw_sel_q;
          w_next     = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          do_commit   = 1'b1;
          commit_data = w_data_q;
          commit_strb = w_strb_q;
          w_next      = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state  <= W_IDLE;
      ready_en <= 1'b0;
      aw_sel_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      w_state  <= w_next;
      ready_en <= 1'b1;
      if (w_state == W_IDLE && aw_hs && !w_hs) aw_sel_q <= S_AXI_AWADDR[3:2];
      if (w_state == W_IDLE && w_hs && !aw_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Shadow copy and read data both see register values from before any same-edge commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      regs_shadow    <= '0;
      shadow_updated <= 1'b0;
    end else begin
      if (do_commit) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (commit_strb[b]) regs[commit_sel][8*b +: 8] <= commit_data[8*b +: 8];
        end
      end
      if (frame_start) regs_shadow <= {regs[3], regs[2], regs[1], regs[0]};
      shadow_updated <= frame_start;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= R_IDLE;
      S_AXI_RDATA <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
            r_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_balls_overlay_axi_regs.sv
// Self-checking bench for balls_overlay_axi_regs: directed scenarios plus randomized
// register traffic scored against an array model of the four registers and the shadow.
module tb_balls_overlay_axi_regs;

  localparam logic [1:0] WS_IDLE    = 2'd0;
  localparam logic [1:0] WS_HAVE_AW = 2'd1;
  localparam logic [1:0] WS_RESP    = 2'd3;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [3:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic         frame_start;
  logic [127:0] regs_shadow;
  logic         shadow_updated;
  logic [1:0]   w_state_dbg;
  logic         r_state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0]  model_regs [4];
  logic [127:0] model_shadow;

  balls_overlay_axi_regs dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .frame_start(frame_start), .regs_shadow(regs_shadow), .shadow_updated(shadow_updated),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // Clock and reset
  always #5 aclk = ~aclk;

  function automatic logic [127:0] model_pack();
    return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  function automatic void model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_regs[addr[3:2]][8*b +: 8] = data[8*b +: 8];
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Driver: AW and W each raised after their own delay; B accepted after b_dly cycles.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_go, w_go;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_go   = awvalid && awready;
      w_go    = wvalid && wready;
      tick();
      if (aw_go) aw_done = 1;
      if (w_go) w_done = 1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("FAIL write_handshake_timeout: aw_done=%0b w_done=%0b required 1 1", aw_done, w_done);
      return;
    end
    model_write(addr, data, strb);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL write_bresp: bvalid=%b bresp=%b required 1 00", bvalid, bresp);
    end
    for (int i = 0; i < b_dly; i++) begin
      tick();
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL write_b_hold: bvalid=%b awready=%b wready=%b required 1 0 0", bvalid, awready, wready);
      end
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_b_drop: bvalid=%b required 0", bvalid);
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input int r_dly);
    bit ar_go = 0;
    bit done = 0;
    int cyc = 0;
    araddr  = addr;
    arvalid = 1'b1;
    while (!done && cyc < 40) begin
      ar_go = arready;
      tick();
      if (ar_go) done = 1;
      cyc++;
    end
    arvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL read_ar_timeout: arready never seen, required handshake");
      return;
    end
    for (int i = 0; i <= r_dly; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp || rresp !== 2'b00) begin
        errors++;
        $display("FAIL read_data addr=%h: rvalid=%b rdata=%h rresp=%b required 1 %h 00", addr, rvalid, rdata, rresp, exp);
      end
      if (i < r_dly) tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_r_drop: rvalid=%b required 0", rvalid);
    end
  endtask

  task automatic frame_pulse();
    model_shadow = model_pack();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (regs_shadow !== model_shadow || shadow_updated !== 1'b1) begin
      errors++;
      $display("FAIL frame_capture: shadow=%h upd=%b required %h 1", regs_shadow, shadow_updated, model_shadow);
    end
    tick();
    checks++;
    if (shadow_updated !== 1'b0) begin
      errors++;
      $display("FAIL frame_pulse_width: upd=%b required 0", shadow_updated);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0; frame_start = 0;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    model_shadow = '0;
    repeat (3) tick();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, shadow_updated} !== 6'b0 || rdata !== 32'h0 ||
        regs_shadow !== 128'h0 || w_state_dbg !== WS_IDLE || r_state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b%b%b bv=%b rv=%b rdata=%h shadow=%h ws=%0d required all zero",
               awready, wready, arready, bvalid, rvalid, rdata, regs_shadow, w_state_dbg);
    end
    aresetn = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_pre_edge: ready=%b required 000", {awready, wready, arready});
    end
    tick();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_idle: ready=%b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'(i + 1), 0);
  endtask

  task automatic test_aw_first();
    awaddr  = 4'h8;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_state_dbg !== WS_HAVE_AW || awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin
        errors++;
        $display("FAIL aw_first_wait: ws=%0d awready=%b wready=%b bvalid=%b required 1 0 1 0",
                 w_state_dbg, awready, wready, bvalid);
      end
      if (i < 2) tick();
    end
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    model_write(4'h8, 32'h1234_5678, 4'hF);
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL aw_first_bvalid: bvalid=%b required 1", bvalid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(4'h8, 32'h1234_5678, 1);
  endtask

  task automatic test_strobe();
    axi_write(4'h4, 32'h0000_0002, 4'hF, 0, 0, 0);
    axi_write(4'h5, 32'hAABB_CCDD, 4'b0010, 1, 0, 0);
    axi_read(4'h4, 32'h0000_CC02, 0);
  endtask

  task automatic test_bready_hold();
    logic [31:0] d1;
    d1 = $urandom;
    awaddr = 4'hC; wdata = d1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(4'hC, d1, 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin awaddr = 4'h0; awvalid = 1'b1; end
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 || w_state_dbg !== WS_RESP) begin
        errors++;
        $display("FAIL bready_hold: bvalid=%b awready=%b wready=%b ws=%0d required 1 0 0 3",
                 bvalid, awready, wready, w_state_dbg);
      end
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (w_state_dbg !== WS_IDLE || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL bready_release: ws=%0d bvalid=%b required 0 0", w_state_dbg, bvalid);
    end
    tick();
    awvalid = 1'b0;
    checks++;
    if (w_state_dbg !== WS_HAVE_AW) begin
      errors++;
      $display("FAIL second_aw_accept: ws=%0d required 1", w_state_dbg);
    end
    wdata = 32'h0BAD_F00D; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    model_write(4'h0, 32'h0BAD_F00D, 4'hF);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(4'hC, d1, 0);
    axi_read(4'h0, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_frame();
    axi_write(4'h0, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    frame_pulse();
    // Write commit and frame_start share one edge: shadow must keep the old value.
    model_shadow = model_pack();
    awaddr = 4'h0; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; frame_start = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; frame_start = 1'b0;
    model_write(4'h0, 32'h5, 4'hF);
    checks++;
    if (regs_shadow[31:0] !== 32'hDEAD_BEEF || regs_shadow !== model_shadow || bvalid !== 1'b1) begin
      errors++;
      $display("FAIL frame_same_edge: shadow0=%h bvalid=%b required deadbeef 1", regs_shadow[31:0], bvalid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    frame_pulse();
    checks++;
    if (regs_shadow[31:0] !== 32'h5) begin
      errors++;
      $display("FAIL frame_next: shadow0=%h required 00000005", regs_shadow[31:0]);
    end
    // Two consecutive pulses stretch shadow_updated to two cycles.
    frame_start = 1'b1;
    tick();
    tick();
    frame_start = 1'b0;
    checks++;
    if (shadow_updated !== 1'b1) begin
      errors++;
      $display("FAIL frame_back_to_back: upd=%b required 1", shadow_updated);
    end
    tick();
    checks++;
    if (shadow_updated !== 1'b0) begin
      errors++;
      $display("FAIL frame_back_to_back_end: upd=%b required 0", shadow_updated);
    end
  endtask

  task automatic test_read_write_same_edge();
    logic [31:0] old_v, new_v;
    old_v = model_regs[1];
    new_v = $urandom;
    awaddr = 4'h4; wdata = new_v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h4; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(4'h4, new_v, 4'hF);
    checks++;
    if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1) begin
      errors++;
      $display("FAIL rw_same_edge: rvalid=%b rdata=%h bvalid=%b required 1 %h 1", rvalid, rdata, bvalid, old_v);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(4'h4, new_v, 0);
  endtask

  task automatic test_random();
    logic [3:0] a;
    for (int n = 0; n < 60; n++) begin
      a = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0, 1, 2: axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 2));
        3, 4:    axi_read(a, model_regs[a[3:2]], $urandom_range(0, 2));
        default: frame_pulse();
      endcase
    end
  endtask

  task automatic test_reset_inflight();
    awaddr = 4'h0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    araddr = 4'h8; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checks++;
    if (w_state_dbg !== WS_HAVE_AW || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL inflight_setup: ws=%0d rvalid=%b required 1 1", w_state_dbg, rvalid);
    end
    #2 aresetn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    model_shadow = '0;
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0 || awready !== 1'b0 || arready !== 1'b0 ||
        w_state_dbg !== WS_IDLE) begin
      errors++;
      $display("FAIL inflight_reset: bvalid=%b rvalid=%b rdata=%h awready=%b arready=%b ws=%0d required 0 0 0 0 0 0",
               bvalid, rvalid, rdata, awready, arready, w_state_dbg);
    end
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
        errors++;
        $display("FAIL inflight_stale_beat: bvalid=%b rvalid=%b required 0 0", bvalid, rvalid);
      end
    end
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), model_regs[i], 0);
    checks++;
    if (regs_shadow !== model_shadow) begin
      errors++;
      $display("FAIL inflight_shadow: shadow=%h required 0", regs_shadow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_first();
    test_strobe();
    test_bready_hold();
    test_frame();
    test_read_write_same_edge();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
